// File: rtl/video_mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// video_mem_arb_pkg : arbiter FSM encoding, write-entry type, defaults
// Revision: 1.0
// ------------------------------------------------------------------
package video_mem_arb_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int ADDR_W             = 16;
  localparam int DATA_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_ACK      = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/video_mem_wfifo.sv
`default_nettype none
// ------------------------------------------------------------------
// video_mem_wfifo : synchronous CPU write buffer (power-of-two depth)
// Revision: 1.0
// ------------------------------------------------------------------
module video_mem_wfifo
  import video_mem_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wr_entry_t              din,
  input  logic                   pop,
  output wr_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wr_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/video_mem_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// video_mem_arb : video-priority arbiter for a single-port sync RAM
// Revision: 1.0
// ------------------------------------------------------------------
module video_mem_arb
  import video_mem_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t                  r_state;
  arb_state_t                  w_state_nxt;
  logic                        r_wr_ack;
  logic                        r_vid_slot;
  logic [DATA_W-1:0]           r_vid_data;
  logic [DATA_W-1:0]           r_cpu_rdata;
  logic [ADDR_W-1:0]           r_mem_addr_hold;
  logic                        w_push;
  logic                        w_drain;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  wr_entry_t                   w_din;
  wr_entry_t                   w_head;

  // The ack cycle still carries cpu_req but is not a fresh request.
  assign w_push  = cpu_req & cpu_we & ~w_full & ~r_wr_ack;
  assign w_drain = (r_state == ST_IDLE) & ~vid_en & ~w_empty;
  assign w_din   = {cpu_addr, cpu_wdata};

  video_mem_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_drain),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Reads wait for an empty FIFO so they never overtake buffered writes.
  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = r_mem_addr_hold;
    mem_we      = 1'b0;
    mem_wdata   = w_head.data;
    case (r_state)
      ST_IDLE:     if (cpu_req && !cpu_we && w_empty) w_state_nxt = ST_RD_ISSUE;
      ST_RD_ISSUE: if (!vid_en) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  w_state_nxt = ST_ACK;
      ST_ACK:      w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (vid_en) begin
      mem_addr = vid_addr;
    end else if (w_drain) begin
      mem_addr = w_head.addr;
      mem_we   = 1'b1;
    end else if (r_state == ST_RD_ISSUE) begin
      mem_addr = cpu_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ack        <= 1'b0;
      r_vid_slot      <= 1'b0;
      r_vid_data      <= '0;
      r_cpu_rdata     <= '0;
      r_mem_addr_hold <= '0;
    end else begin
      r_wr_ack        <= w_push;
      r_vid_slot      <= vid_en;
      r_mem_addr_hold <= mem_addr;
      if (r_vid_slot) r_vid_data <= mem_rdata;
      // Captured even if video has taken the port back this cycle.
      if (r_state == ST_RD_WAIT) r_cpu_rdata <= mem_rdata;
    end
  end

  assign vid_data  = r_vid_slot ? mem_rdata : r_vid_data;
  assign cpu_ack   = r_wr_ack | (r_state == ST_ACK);
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_busy  = (w_count != '0) | (r_state != ST_IDLE);

endmodule
`default_nettype wire
